// File: rtl/mips_multicycle_ctrl.sv
// Main controller for the multicycle MIPS core: Moore FSM sequencing the shared
// ALU, unified memory port, IR and register file, with a few Mealy handshake terms.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_q, state_d;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic       pcwrite, branch;
  logic       irwrite_raw, memwrite_raw, regwrite_raw, done_raw, illegal_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'b010;
    case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = FETCH;
    iord         = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    alucontrol   = 3'b010;
    pcsrc        = 2'b00;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    done_raw     = 1'b0;
    illegal_raw  = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb     = 2'b01;
        irwrite_raw = mem_ready;
        pcwrite     = mem_ready;
        state_d     = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // ALUOut captures PC+4 + (SignImm<<2) for a possible branch
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE: begin
            if (funct_ok) state_d = EXECUTE;
            else          illegal_raw = 1'b1;
          end
          OP_BEQ:  state_d = BRANCH;
          OP_ADDI: state_d = ADDIEXEC;
          OP_J:    state_d = JUMP;
          default: illegal_raw = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        done_raw     = mem_ready;
        state_d      = mem_ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
        state_d    = ALUWB;
      end
      ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        done_raw   = 1'b1;
      end
      ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      JUMP: begin
        pcsrc    = 2'b10;
        pcwrite  = 1'b1;
        done_raw = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Write enables and pulses are killed as soon as reset asserts, before any edge
  assign irwrite    = irwrite_raw & reset;
  assign memwrite   = memwrite_raw & reset;
  assign regwrite   = regwrite_raw & reset;
  assign pcen       = (pcwrite | (branch & zero)) & reset;
  assign instr_done = done_raw & reset;
  assign illegal    = illegal_raw & reset;
  assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: directed per-cycle vectors push
// expected state/enables/selects; a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       pcen, instr_done, illegal;
  logic [3:0] state;

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [5:0]  we;
    logic        chk_sel;
    logic [10:0] sel;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // enable vector order: {irwrite, memwrite, regwrite, pcen, instr_done, illegal}
  localparam logic [5:0] W_NONE  = 6'b000000;
  localparam logic [5:0] W_FETCH = 6'b100100;
  localparam logic [5:0] W_WB    = 6'b001010;
  localparam logic [5:0] W_PCDN  = 6'b000110;
  localparam logic [5:0] W_DONE  = 6'b000010;
  localparam logic [5:0] W_MW    = 6'b010000;
  localparam logic [5:0] W_MWD   = 6'b010010;
  localparam logic [5:0] W_ILL   = 6'b000001;

  localparam logic [5:0] F_ADD = 6'b100000;

  logic [10:0] s_fetch, s_dec, s_madr, s_mem, s_memwb, s_exadd, s_exsub, s_exslt;
  logic [10:0] s_aluwb, s_br, s_addiex, s_addiwb, s_jump;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .alucontrol(alucontrol), .pcsrc(pcsrc), .pcen(pcen),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] sel_v(logic i, logic rd, logic m2r, logic a,
                                        logic [1:0] b, logic [2:0] alu, logic [1:0] p);
    return {i, rd, m2r, a, b, alu, p};
  endfunction

  // one cycle: drive inputs just after the edge and queue what the DUT should show
  task automatic apply_stimulus(string nm, logic rst, logic mr, logic z,
                                logic [5:0] o, logic [5:0] f, logic [3:0] st,
                                logic [5:0] we, logic cs, logic [10:0] sel);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; mem_ready = mr; zero = z; op = o; funct = f;
    e.name = nm; e.st = st; e.we = we; e.chk_sel = cs; e.sel = sel;
    exp_q.push_back(e);
  endtask

  task automatic check_output(exp_t e);
    logic [5:0]  we_act;
    logic [10:0] sel_act;
    we_act  = {irwrite, memwrite, regwrite, pcen, instr_done, illegal};
    sel_act = {iord, regdst, memtoreg, alusrca, alusrcb, alucontrol, pcsrc};
    total++;
    if (state !== e.st) begin
      bad++;
      $display("[TB] FAIL %s state: got %0d want %0d", e.name, state, e.st);
    end
    total++;
    if (we_act !== e.we) begin
      bad++;
      $display("[TB] FAIL %s enables: got %b want %b", e.name, we_act, e.we);
    end
    if (e.chk_sel) begin
      total++;
      if (sel_act !== e.sel) begin
        bad++;
        $display("[TB] FAIL %s selects: got %b want %b", e.name, sel_act, e.sel);
      end
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) check_output(exp_q.pop_front());
  end

  initial begin
    s_fetch  = sel_v(0, 0, 0, 0, 2'b01, 3'b010, 2'b00);
    s_dec    = sel_v(0, 0, 0, 0, 2'b11, 3'b010, 2'b00);
    s_madr   = sel_v(0, 0, 0, 1, 2'b10, 3'b010, 2'b00);
    s_mem    = sel_v(1, 0, 0, 0, 2'b00, 3'b010, 2'b00);
    s_memwb  = sel_v(0, 0, 1, 0, 2'b00, 3'b010, 2'b00);
    s_exadd  = sel_v(0, 0, 0, 1, 2'b00, 3'b010, 2'b00);
    s_exsub  = sel_v(0, 0, 0, 1, 2'b00, 3'b110, 2'b00);
    s_exslt  = sel_v(0, 0, 0, 1, 2'b00, 3'b111, 2'b00);
    s_aluwb  = sel_v(0, 1, 0, 0, 2'b00, 3'b010, 2'b00);
    s_br     = sel_v(0, 0, 0, 1, 2'b00, 3'b110, 2'b01);
    s_addiex = sel_v(0, 0, 0, 1, 2'b10, 3'b010, 2'b00);
    s_addiwb = sel_v(0, 0, 0, 0, 2'b00, 3'b010, 2'b00);
    s_jump   = sel_v(0, 0, 0, 0, 2'b00, 3'b010, 2'b10);

    reset = 1'b0; mem_ready = 1'b1; zero = 1'b0; op = 6'd0; funct = F_ADD;

    // reset held with mem_ready high: FETCH selects, no enables
    apply_stimulus("rst",       0, 1, 0, 6'b000000, F_ADD, 4'd0, W_NONE,  1, s_fetch);

    // add, zero wait states
    apply_stimulus("add_f",     1, 1, 0, 6'b000000, F_ADD, 4'd0, W_FETCH, 1, s_fetch);
    apply_stimulus("add_d",     1, 1, 0, 6'b000000, F_ADD, 4'd1, W_NONE,  1, s_dec);
    apply_stimulus("add_ex",    1, 1, 0, 6'b000000, F_ADD, 4'd6, W_NONE,  1, s_exadd);
    apply_stimulus("add_wb",    1, 1, 0, 6'b000000, F_ADD, 4'd7, W_WB,    1, s_aluwb);

    // lw: 2 wait cycles in FETCH, 3 in MEMRD -> 10 cycles
    apply_stimulus("lw_fw0",    1, 0, 0, 6'b100011, 6'd0, 4'd0, W_NONE,  1, s_fetch);
    apply_stimulus("lw_fw1",    1, 0, 0, 6'b100011, 6'd0, 4'd0, W_NONE,  0, s_fetch);
    apply_stimulus("lw_f",      1, 1, 0, 6'b100011, 6'd0, 4'd0, W_FETCH, 0, s_fetch);
    apply_stimulus("lw_d",      1, 1, 0, 6'b100011, 6'd0, 4'd1, W_NONE,  0, s_dec);
    apply_stimulus("lw_adr",    1, 1, 0, 6'b100011, 6'd0, 4'd2, W_NONE,  1, s_madr);
    for (int i = 0; i < 3; i++)
      apply_stimulus("lw_rdw",  1, 0, 0, 6'b100011, 6'd0, 4'd3, W_NONE,  1, s_mem);
    apply_stimulus("lw_rd",     1, 1, 0, 6'b100011, 6'd0, 4'd3, W_NONE,  1, s_mem);
    apply_stimulus("lw_wb",     1, 1, 0, 6'b100011, 6'd0, 4'd4, W_WB,    1, s_memwb);

    // beq taken, then not taken
    apply_stimulus("beqt_f",    1, 1, 1, 6'b000100, 6'd0, 4'd0, W_FETCH, 0, s_fetch);
    apply_stimulus("beqt_d",    1, 1, 1, 6'b000100, 6'd0, 4'd1, W_NONE,  0, s_dec);
    apply_stimulus("beqt_br",   1, 1, 1, 6'b000100, 6'd0, 4'd8, W_PCDN,  1, s_br);
    apply_stimulus("beqn_f",    1, 1, 0, 6'b000100, 6'd0, 4'd0, W_FETCH, 0, s_fetch);
    apply_stimulus("beqn_d",    1, 1, 0, 6'b000100, 6'd0, 4'd1, W_NONE,  0, s_dec);
    apply_stimulus("beqn_br",   1, 1, 0, 6'b000100, 6'd0, 4'd8, W_DONE,  1, s_br);

    // sw: memwrite held for 3 cycles, instr_done only in the last
    apply_stimulus("sw_f",      1, 1, 0, 6'b101011, 6'd0, 4'd0, W_FETCH, 0, s_fetch);
    apply_stimulus("sw_d",      1, 1, 0, 6'b101011, 6'd0, 4'd1, W_NONE,  0, s_dec);
    apply_stimulus("sw_adr",    1, 1, 0, 6'b101011, 6'd0, 4'd2, W_NONE,  1, s_madr);
    apply_stimulus("sw_w0",     1, 0, 0, 6'b101011, 6'd0, 4'd5, W_MW,    1, s_mem);
    apply_stimulus("sw_w1",     1, 0, 0, 6'b101011, 6'd0, 4'd5, W_MW,    1, s_mem);
    apply_stimulus("sw_wr",     1, 1, 0, 6'b101011, 6'd0, 4'd5, W_MWD,   1, s_mem);

    // illegal opcode, then illegal R-type funct
    apply_stimulus("ilop_f",    1, 1, 0, 6'b111111, 6'd0, 4'd0, W_FETCH, 0, s_fetch);
    apply_stimulus("ilop_d",    1, 1, 0, 6'b111111, 6'd0, 4'd1, W_ILL,   1, s_dec);
    apply_stimulus("ilfn_f",    1, 1, 0, 6'b000000, 6'b000111, 4'd0, W_FETCH, 0, s_fetch);
    apply_stimulus("ilfn_d",    1, 1, 0, 6'b000000, 6'b000111, 4'd1, W_ILL,   1, s_dec);

    // addi and j
    apply_stimulus("addi_f",    1, 1, 0, 6'b001000, 6'd0, 4'd0, W_FETCH, 0, s_fetch);
    apply_stimulus("addi_d",    1, 1, 0, 6'b001000, 6'd0, 4'd1, W_NONE,  0, s_dec);
    apply_stimulus("addi_ex",   1, 1, 0, 6'b001000, 6'd0, 4'd9, W_NONE,  1, s_addiex);
    apply_stimulus("addi_wb",   1, 1, 0, 6'b001000, 6'd0, 4'd10, W_WB,   1, s_addiwb);
    apply_stimulus("j_f",       1, 1, 0, 6'b000010, 6'd0, 4'd0, W_FETCH, 0, s_fetch);
    apply_stimulus("j_d",       1, 1, 0, 6'b000010, 6'd0, 4'd1, W_NONE,  0, s_dec);
    apply_stimulus("j_jmp",     1, 1, 0, 6'b000010, 6'd0, 4'd11, W_PCDN, 1, s_jump);

    // sub and slt ALU decode in EXECUTE
    apply_stimulus("sub_f",     1, 1, 0, 6'b000000, 6'b100010, 4'd0, W_FETCH, 0, s_fetch);
    apply_stimulus("sub_d",     1, 1, 0, 6'b000000, 6'b100010, 4'd1, W_NONE,  0, s_dec);
    apply_stimulus("sub_ex",    1, 1, 0, 6'b000000, 6'b100010, 4'd6, W_NONE,  1, s_exsub);
    apply_stimulus("sub_wb",    1, 1, 0, 6'b000000, 6'b100010, 4'd7, W_WB,    1, s_aluwb);
    apply_stimulus("slt_f",     1, 1, 0, 6'b000000, 6'b101010, 4'd0, W_FETCH, 0, s_fetch);
    apply_stimulus("slt_d",     1, 1, 0, 6'b000000, 6'b101010, 4'd1, W_NONE,  0, s_dec);
    apply_stimulus("slt_ex",    1, 1, 0, 6'b000000, 6'b101010, 4'd6, W_NONE,  1, s_exslt);
    apply_stimulus("slt_wb",    1, 1, 0, 6'b000000, 6'b101010, 4'd7, W_WB,    1, s_aluwb);

    // async reset dropped after entering MEMWR, mid-cycle
    apply_stimulus("ar_f",      1, 1, 0, 6'b101011, 6'd0, 4'd0, W_FETCH, 0, s_fetch);
    apply_stimulus("ar_d",      1, 1, 0, 6'b101011, 6'd0, 4'd1, W_NONE,  0, s_dec);
    apply_stimulus("ar_adr",    1, 1, 0, 6'b101011, 6'd0, 4'd2, W_NONE,  0, s_madr);
    apply_stimulus("ar_wr",     1, 0, 0, 6'b101011, 6'd0, 4'd5, W_MW,    1, s_mem);
    apply_stimulus("ar_drop",   0, 0, 0, 6'b101011, 6'd0, 4'd0, W_NONE,  1, s_fetch);
    apply_stimulus("ar_hold",   0, 1, 0, 6'b000000, F_ADD, 4'd0, W_NONE, 1, s_fetch);
    apply_stimulus("ar_f2",     1, 1, 0, 6'b000000, F_ADD, 4'd0, W_FETCH, 1, s_fetch);
    apply_stimulus("ar_d2",     1, 1, 0, 6'b000000, F_ADD, 4'd1, W_NONE,  1, s_dec);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main controller for the multicycle MIPS core: a Moore FSM that sequences the shared ALU, single unified memory port, instruction register and register file over several clock cycles per instruction. Inputs are the opcode/funct fields of the instruction register, the ALU zero flag and a memory-ready handshake. Outputs are the datapath mux selects and write enables. It replaces the single-cycle decoder inside `top`.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `op` in 6: instr[31:26] from the instruction register.
- `funct` in 6: instr[5:0] from the instruction register.
- `zero` in 1: ALU zero flag, combinational from the current cycle.
- `mem_ready` in 1: memory completes the current access this cycle.
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `memwrite` out 1: memory write enable.
- `irwrite` out 1: instruction register load.
- `regdst` out 1: register write address select, 1 = rd, 0 = rt.
- `memtoreg` out 1: register write data select, 1 = memory data, 0 = ALUOut.
- `regwrite` out 1: register file write enable.
- `alusrca` out 1: ALU A select, 0 = PC, 1 = register A.
- `alusrcb` out 2: ALU B select, 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `alucontrol` out 3: ALU operation, 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `pcsrc` out 2: next PC select, 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `pcen` out 1: PC load enable, equal to pcwrite | (branch & zero).
- `instr_done` out 1: one-cycle pulse in the last cycle of each retired instruction.
- `illegal` out 1: one-cycle pulse in DECODE when the opcode or funct is unsupported.
- `state` out 4: current state encoding, for debug.

## Operation
- Supported opcodes:
  - lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
  - R-type funct values: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11.
- Any unused encoding goes to FETCH on the next edge.
- FETCH
  - Outputs: iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00.
  - irwrite and pcwrite are asserted only when mem_ready=1.
  - mem_ready=1: go to DECODE. Otherwise stay in FETCH.
- DECODE
  - Outputs: alusrca=0, alusrcb=11, alucontrol=010, which computes the branch target into ALUOut.
  - Next state by opcode:
    - lw or sw: MEMADR.
    - R-type with a supported funct: EXECUTE.
    - beq: BRANCH.
    - addi: ADDIEXEC.
    - j: JUMP.
    - Anything else: FETCH, with `illegal` pulsed. The PC has already advanced, so the instruction acts as a NOP.
- MEMADR
  - Outputs: alusrca=1, alusrcb=10, alucontrol=010.
  - Next state: lw goes to MEMRD, sw goes to MEMWR.
- MEMRD
  - Outputs: iord=1.
  - mem_ready=1: go to MEMWB. Otherwise stay.
- MEMWB
  - Outputs: regdst=0, memtoreg=1, regwrite=1, instr_done=1.
  - Next state: FETCH.
- MEMWR
  - Outputs: iord=1, memwrite=1. memwrite stays high every cycle until mem_ready=1.
  - instr_done=1 in the mem_ready cycle, then go to FETCH.
- EXECUTE
  - Outputs: alusrca=1, alusrcb=00, alucontrol decoded from funct.
  - Next state: ALUWB.
- ALUWB
  - Outputs: regdst=1, memtoreg=0, regwrite=1, instr_done=1.
  - Next state: FETCH.
- BRANCH
  - Outputs: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch=1, instr_done=1.
  - Next state: FETCH.
- ADDIEXEC
  - Outputs: alusrca=1, alusrcb=10, alucontrol=010.
  - Next state: ADDIWB.
- ADDIWB
  - Outputs: regdst=0, memtoreg=0, regwrite=1, instr_done=1.
  - Next state: FETCH.
- JUMP
  - Outputs: pcsrc=10, pcwrite=1, instr_done=1.
  - Next state: FETCH.
- Every output not listed for a state is 0. alucontrol defaults to 010.
- All outputs are combinational from `state` only, except these Mealy terms:
  - irwrite and pcen in FETCH depend on mem_ready.
  - memwrite and instr_done in MEMWR depend on mem_ready.
  - pcen in BRANCH depends on zero.

## Timing
- The state register updates on the rising edge of clk.
- Reset:
  - reset=0 forces state=FETCH immediately, with no clock edge needed.
  - While reset=0, all write enables (irwrite, memwrite, regwrite, pcen) and the pulses (instr_done, illegal) are forced to 0.
  - Mux selects show their FETCH values during reset.
  - The first fetch starts on the first rising edge after reset returns to 1.
- Cycles per instruction with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- No write enable pulses during a wait cycle, except memwrite held high in MEMWR.
- Reset asserted mid-instruction abandons it. No further writes occur after the asynchronous assertion.
- op and funct must be stable from the cycle after the irwrite edge until the next FETCH. The FSM samples them only in DECODE and in MEMADR/EXECUTE.

## Test plan
- Reset, then mem_ready tied to 1, fetch R-type add (op 000000, funct 100000):
  - state sequence 0,1,6,7,0.
  - ALUWB cycle has regwrite=1, regdst=1, alucontrol=010.
  - instr_done pulses once.
- lw with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD:
  - Instruction takes 10 cycles.
  - irwrite is high only in the single mem_ready=1 FETCH cycle.
  - MEMWB cycle has memtoreg=1, regwrite=1.
- beq with zero=1:
  - pcen=1, pcsrc=01 in BRANCH.
  - Repeating with zero=0 gives pcen=0. Both take 3 cycles.
- sw with mem_ready=0 for 2 cycles in MEMWR:
  - memwrite is high for 3 consecutive cycles.
  - instr_done is high only in the last of them.
- Illegal opcode 111111, then R-type funct 000111:
  - Each goes 0,1,0 with illegal=1 in DECODE.
  - regwrite and memwrite stay 0 throughout.
- Async reset dropped mid-MEMWR (without waiting for a clock edge):
  - state=0 and memwrite=0 within the same cycle.
  - After release, the next fetch starts at FETCH.
